// File: rtl/dsd_pkg.sv
// Shared definitions for the DSD sample source.
//   src_state_t    : replay FSM state encoding
//   get_bus_width(): address width for a buffer of the given depth (never below 1)
package dsd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } src_state_t;

  function automatic int get_bus_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dsd_sample_buffer.sv
// Sample storage for the DSD sample source.
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module dsd_sample_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dsd_sample_source.sv
// DSD sample source: replays a host-preloaded buffer as one-cycle valid
// pulses into the averaging filter's push-only input.
//   clk, rst            : clock, synchronous active-high reset
//   load_data_i/valid_i : append a sample (IDLE only, while not full)
//   load_ready_o        : IDLE and buffer not full
//   clear_i             : IDLE only, empties the buffer
//   start_i             : IDLE only, begins a run and latches gap_i/loop_i
//   stop_i              : aborts a run in progress
//   loop_i, gap_i       : wrap-around enable, idle cycles after each sample
//   data_o/valid_o      : sample stream (data_o is 0 when not valid)
//   busy_o, done_o      : run in progress, one-cycle end-of-run pulse
//   count_o             : samples emitted since last start (saturating)
module dsd_sample_source
  import dsd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 16,
  parameter int GAP_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  loop_i,
  input  logic [GAP_WIDTH-1:0]  gap_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  count_o
);

  localparam int AW = get_bus_width(BUF_DEPTH);
  localparam int LW = AW + 1;

  src_state_t            state_reg, state_next;
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]         length_reg;
  logic [GAP_WIDTH-1:0]  gap_reg, gap_cnt_reg;
  logic                  loop_reg;
  logic [CNT_WIDTH-1:0]  count_reg;

  logic                  full;
  logic                  load_accept;
  logic                  last;
  logic                  start_go;
  logic [DATA_WIDTH-1:0] rd_data;

  assign full         = (length_reg == LW'(BUF_DEPTH));
  assign load_ready_o = (state_reg == IDLE) && !full;
  // clear has priority over a simultaneous load
  assign load_accept  = load_valid_i && load_ready_o && !clear_i;
  // entry being emitted is the final one of the buffer
  assign last         = ({1'b0, rd_ptr_reg} == (length_reg - LW'(1)));
  // a load in the start cycle counts toward the run even if length is still 0
  assign start_go     = !clear_i && ((length_reg != '0) || load_accept);

  dsd_sample_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH),
    .AW         (AW)
  ) u_buffer (
    .clk   (clk),
    .we    (load_accept),
    .waddr (wr_ptr_reg),
    .wdata (load_data_i),
    .raddr (rd_ptr_reg),
    .rdata (rd_data)
  );

  // state register and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      length_reg  <= '0;
      gap_reg     <= '0;
      gap_cnt_reg <= '0;
      loop_reg    <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (clear_i) begin
            length_reg <= '0;
            wr_ptr_reg <= '0;
          end else if (load_accept) begin
            length_reg <= length_reg + LW'(1);
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
          end
          if (start_i) begin
            gap_reg    <= gap_i;
            loop_reg   <= loop_i;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
          end
        end
        SEND: begin
          rd_ptr_reg  <= last ? '0 : rd_ptr_reg + AW'(1);
          // preload so the GAP state lasts exactly gap_reg cycles
          gap_cnt_reg <= gap_reg - GAP_WIDTH'(1);
          if (count_reg != '1) begin
            count_reg <= count_reg + CNT_WIDTH'(1);
          end
        end
        GAP: begin
          if (gap_cnt_reg != '0) begin
            gap_cnt_reg <= gap_cnt_reg - GAP_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = start_go ? SEND : FINISH;
        end
      end
      SEND: begin
        // ending a single pass beats any trailing gap
        if (stop_i || (last && !loop_reg)) begin
          state_next = FINISH;
        end else if (gap_reg != '0) begin
          state_next = GAP;
        end else begin
          state_next = SEND;
        end
      end
      GAP: begin
        if (stop_i) begin
          state_next = FINISH;
        end else if (gap_cnt_reg == '0) begin
          state_next = SEND;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // outputs decoded from registered state only
  always_comb begin
    valid_o = 1'b0;
    data_o  = '0;
    busy_o  = (state_reg != IDLE);
    done_o  = (state_reg == FINISH);
    count_o = count_reg;
    if (state_reg == SEND) begin
      valid_o = 1'b1;
      data_o  = rd_data;
    end
  end

endmodule

// File: tb/tb_dsd_sample_source.sv
// Directed bench for dsd_sample_source: expected pulses (data and cycle) are
// queued as each run is started and compared against what the monitor saw.
module tb_dsd_sample_source;

  localparam int DATA_WIDTH = 32;
  localparam int BUF_DEPTH  = 16;
  localparam int GAP_WIDTH  = 8;
  localparam int CNT_WIDTH  = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [DATA_WIDTH-1:0] load_data_i = '0;
  logic                  load_valid_i = 1'b0;
  logic                  load_ready_o;
  logic                  clear_i = 1'b0;
  logic                  start_i = 1'b0;
  logic                  stop_i = 1'b0;
  logic                  loop_i = 1'b0;
  logic [GAP_WIDTH-1:0]  gap_i = '0;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  busy_o;
  logic                  done_o;
  logic [CNT_WIDTH-1:0]  count_o;

  dsd_sample_source #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH),
    .GAP_WIDTH  (GAP_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_data_i  (load_data_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .loop_i       (loop_i),
    .gap_i        (gap_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    int                    cyc;
  } exp_t;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nz_data = 0;
  int   run_base = 0;
  int   obs_idx = 0;
  int   done_idx = 0;
  exp_t exp_q[$];
  logic [DATA_WIDTH-1:0] obs_data[$];
  int   obs_cyc[$];
  int   done_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // passive monitor: records every pulse and end-of-run
  always @(negedge clk) begin
    if (valid_o) begin
      obs_data.push_back(data_o);
      obs_cyc.push_back(cyc);
      $display("pulse  cyc=%0d data=%0d count=%0d", cyc, data_o, count_o);
    end
    if (done_o) begin
      done_cyc.push_back(cyc);
      $display("done   cyc=%0d count=%0d", cyc, count_o);
    end
    if (!valid_o && data_o != '0) nz_data++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [DATA_WIDTH-1:0] v, input logic exp_ready);
    load_data_i  = v;
    load_valid_i = 1'b1;
    check("load_ready", load_ready_o, exp_ready);
    tick();
    load_valid_i = 1'b0;
  endtask

  task automatic clear_buf();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic start_run(input int g, input logic lp);
    gap_i    = g[GAP_WIDTH-1:0];
    loop_i   = lp;
    start_i  = 1'b1;
    run_base = cyc;
    tick();
    start_i  = 1'b0;
  endtask

  task automatic push_exp(input logic [DATA_WIDTH-1:0] d, input int off);
    exp_t e;
    e.data = d;
    e.cyc  = run_base + off;
    exp_q.push_back(e);
  endtask

  // run to a fixed cycle past the expected end, then score pulses and done
  task automatic finish_run(input int done_off, input logic expect_done);
    int target;
    int n;
    exp_t e;
    target = run_base + done_off + 3;
    while (cyc < target) tick();
    n = obs_data.size() - obs_idx;
    check("pulse_count", n, exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_idx < obs_data.size()) begin
        check("pulse_data", obs_data[obs_idx], e.data);
        check("pulse_cyc", obs_cyc[obs_idx], e.cyc);
        obs_idx++;
      end
    end
    obs_idx = obs_data.size();
    n = done_cyc.size() - done_idx;
    check("done_count", n, expect_done ? 1 : 0);
    if (expect_done && n > 0) check("done_cyc", done_cyc[done_idx], run_base + done_off);
    done_idx = done_cyc.size();
    check("busy_after", busy_o, 1'b0);
  endtask

  initial begin
    logic [DATA_WIDTH-1:0] vals [4];
    logic [DATA_WIDTH-1:0] loop_seq [7];
    logic [DATA_WIDTH+2:0] sum;
    int idx0;
    vals     = '{32'd4, 32'd8, 32'd12, 32'd16};
    loop_seq = '{32'd1, 32'd2, 32'd3, 32'd1, 32'd2, 32'd3, 32'd1};

    // reset state
    repeat (3) tick();
    check("rst_valid", valid_o, 1'b0);
    check("rst_data", data_o, '0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_count", count_o, '0);
    check("rst_ready", load_ready_o, 1'b1);
    rst = 1'b0;
    tick();

    // back-to-back single pass
    for (int i = 0; i < 4; i++) load(vals[i], 1'b1);
    start_run(0, 1'b0);
    for (int k = 0; k < 4; k++) push_exp(vals[k], 1 + k);
    idx0 = obs_idx;
    finish_run(5, 1'b1);
    check("count_run1", count_o, 16'd4);
    sum = '0;
    if (obs_data.size() >= idx0 + 4)
      for (int k = 0; k < 4; k++) sum = sum + obs_data[idx0 + k];
    check("filter_avg", sum >> 2, 10);

    // same buffer with gap=2
    start_run(2, 1'b0);
    for (int k = 0; k < 4; k++) push_exp(vals[k], 1 + 3 * k);
    finish_run(11, 1'b1);
    check("count_run2", count_o, 16'd4);

    // loop run, gap/loop changed while busy (ignored), stopped after 7 pulses
    clear_buf();
    for (int i = 1; i <= 3; i++) load(DATA_WIDTH'(i), 1'b1);
    start_run(0, 1'b1);
    gap_i  = 8'd5;
    loop_i = 1'b0;
    repeat (6) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    for (int k = 0; k < 7; k++) push_exp(loop_seq[k], 1 + k);
    finish_run(8, 1'b1);
    check("count_loop", count_o, 16'd7);

    // overfill: 17th load is refused
    clear_buf();
    for (int i = 0; i < 17; i++) load(DATA_WIDTH'(100 + i), (i < BUF_DEPTH) ? 1'b1 : 1'b0);
    start_run(0, 1'b0);
    for (int k = 0; k < BUF_DEPTH; k++) push_exp(DATA_WIDTH'(100 + k), 1 + k);
    finish_run(17, 1'b1);
    check("count_full", count_o, 16'd16);

    // empty start
    clear_buf();
    start_run(0, 1'b0);
    finish_run(1, 1'b1);
    check("count_empty", count_o, 16'd0);

    // clear and load together: load dropped, next start is empty
    clear_i      = 1'b1;
    load_valid_i = 1'b1;
    load_data_i  = 32'd55;
    tick();
    clear_i      = 1'b0;
    load_valid_i = 1'b0;
    start_run(0, 1'b0);
    finish_run(1, 1'b1);

    // clear and start together: clear wins, empty run
    load(32'd77, 1'b1);
    clear_i = 1'b1;
    start_run(0, 1'b0);
    clear_i = 1'b0;
    finish_run(1, 1'b1);

    // reset during GAP of a loop run
    load(32'd5, 1'b1);
    load(32'd6, 1'b1);
    start_run(3, 1'b1);
    push_exp(32'd5, 1);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_count", count_o, '0);
    check("midrst_done", done_o, 1'b0);
    rst = 1'b0;
    finish_run(3, 1'b0);

    // normal operation after reset
    load(32'd9, 1'b1);
    start_run(0, 1'b0);
    push_exp(32'd9, 1);
    finish_run(2, 1'b1);
    check("count_post_rst", count_o, 16'd1);

    check("idle_data_zero", nz_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
